// File: rtl/stdout_uart_tx.sv
// Stdout character drain: accepts tagged chars and serializes them as 8N1 UART frames.
// Optional `[c,k] ` line prefixing and source-switch line splitting under STDOUT_UART_TAG_EN.
module stdout_uart_tx #(
  parameter int N_CLUSTERS = 4,
  parameter int N_CORES    = 8,
  parameter int CLK_DIV    = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_data_i,
  output logic        tx_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_NL, S_PFX0, S_PFX1, S_PFX2, S_PFX3, S_PFX4, S_PFX5, S_CHAR, S_WAIT
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  function automatic logic [7:0] hex_digit(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
  endfunction

  function automatic logic [7:0] state_byte(input state_t s, input logic [3:0] cl,
                                            input logic [3:0] core, input logic [7:0] ch);
    case (s)
      S_NL:    return 8'h0A;
      S_PFX0:  return 8'h5B;
      S_PFX1:  return hex_digit(cl);
      S_PFX2:  return 8'h2C;
      S_PFX3:  return hex_digit(core);
      S_PFX4:  return 8'h5D;
      S_PFX5:  return 8'h20;
      default: return ch;
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      S_NL:    return S_PFX0;
      S_PFX0:  return S_PFX1;
      S_PFX1:  return S_PFX2;
      S_PFX2:  return S_PFX3;
      S_PFX3:  return S_PFX4;
      S_PFX4:  return S_PFX5;
      S_PFX5:  return S_CHAR;
      default: return S_IDLE;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cl_q, core_q;
  logic [7:0]  char_q;
  logic        ser_active_q, tx_q;
  logic [7:0]  ser_byte_q;
  logic [3:0]  bit_cnt_q;
  logic [15:0] div_cnt_q;
  logic        load, ser_done, in_rng;
  logic [7:0]  load_byte;

  wire [3:0] in_cl   = in_data_i[15:12];
  wire [3:0] in_core = in_data_i[11:8];
  wire [7:0] in_char = in_data_i[7:0];

  assign in_rng   = ({28'd0, in_cl} < 32'(N_CLUSTERS)) && ({28'd0, in_core} < 32'(N_CORES));
  assign ser_done = ser_active_q && (bit_cnt_q == 4'd9) && (div_cnt_q == DIV_LAST);

`ifdef STDOUT_UART_TAG_EN
  logic       line_start_q, line_start_d;
  logic [7:0] last_src_q, last_src_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_start_q <= 1'b1;
      last_src_q   <= '0;
    end else begin
      line_start_q <= line_start_d;
      last_src_q   <= last_src_d;
    end
  end
`endif

  // The first byte of an entry is loaded on the handshake edge so the start bit
  // follows the handshake by one cycle; later bytes load on the stop-bit end.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_byte = '0;
`ifdef STDOUT_UART_TAG_EN
    line_start_d = line_start_q;
    last_src_d   = last_src_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (!in_rng) state_d = S_WAIT;
`ifdef STDOUT_UART_TAG_EN
          else if (in_char == 8'h0A && line_start_q) state_d = S_WAIT;
          else if (in_char == 8'h0A) begin
            state_d      = S_CHAR;
            line_start_d = 1'b1;
          end else if (line_start_q) begin
            state_d      = S_PFX0;
            line_start_d = 1'b0;
            last_src_d   = in_data_i[15:8];
          end else if (in_data_i[15:8] != last_src_q) begin
            state_d    = S_NL;
            last_src_d = in_data_i[15:8];
          end else state_d = S_CHAR;
`else
          else state_d = S_CHAR;
`endif
          load      = (state_d != S_WAIT);
          load_byte = state_byte(state_d, in_cl, in_core, in_char);
        end
      end
      S_WAIT: if (!ser_active_q) state_d = S_IDLE;
      default: begin
        if (ser_done) begin
          state_d = succ(state_q);
          if (state_d != S_IDLE) begin
            load      = 1'b1;
            load_byte = state_byte(state_d, cl_q, core_q, char_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cl_q    <= '0;
      core_q  <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && in_valid_i) begin
        cl_q   <= in_cl;
        core_q <= in_core;
        char_q <= in_char;
      end
    end
  end

  // Bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ser_active_q <= 1'b0;
      ser_byte_q   <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      tx_q         <= 1'b1;
    end else if (load) begin
      ser_active_q <= 1'b1;
      ser_byte_q   <= load_byte;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      tx_q         <= 1'b0;
    end else if (ser_active_q) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_q <= '0;
        if (bit_cnt_q == 4'd9) begin
          ser_active_q <= 1'b0;
          bit_cnt_q    <= '0;
          tx_q         <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          tx_q      <= (bit_cnt_q == 4'd8) ? 1'b1 : ser_byte_q[bit_cnt_q[2:0]];
        end
      end else begin
        div_cnt_q <= div_cnt_q + 16'd1;
      end
    end
  end

  assign tx_o       = tx_q;
  assign in_ready_o = (state_q == S_IDLE);
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Self-checking bench for stdout_uart_tx: UART decoder plus a byte-stream reference model.
// Tag-specific expectations follow STDOUT_UART_TAG_EN.
module tb_stdout_uart_tx;
  localparam int CD  = 4;
  localparam int NCL = 4;
  localparam int NCO = 12;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_data_i;
  logic        tx_o;
  logic        busy_o;

  int nchecks = 0;
  int nfail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         frame_err = 0;

  // Reference model state
  bit         m_ls   = 1'b1;
  logic [7:0] m_last = '0;

  stdout_uart_tx #(.N_CLUSTERS(NCL), .N_CORES(NCO), .CLK_DIV(CD)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .tx_o(tx_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // UART receiver sampling mid-bit on the falling edge
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte;
  always @(negedge clk) begin
    if (rst_i) rx_act = 1'b0;
    else if (!rx_act) begin
      if (tx_o == 1'b0) begin rx_act = 1'b1; rx_cnt = 0; end
    end else rx_cnt++;
    if (rx_act && !rst_i) begin
      if (rx_cnt % CD == CD / 2 && rx_cnt / CD >= 1 && rx_cnt / CD <= 8)
        rx_byte[rx_cnt / CD - 1] = tx_o;
      if (rx_cnt == 9 * CD + CD / 2) begin
        if (tx_o !== 1'b1) frame_err++;
        rx_q.push_back(rx_byte);
      end
      if (rx_cnt == 10 * CD - 1) rx_act = 1'b0;
    end
  end

  function automatic logic [7:0] hexc(input int d);
    return (d < 10) ? 8'(48 + d) : 8'(97 + d - 10);
  endfunction

  task automatic model_entry(input logic [15:0] d);
    int cl = int'(d[15:12]);
    int co = int'(d[11:8]);
    logic [7:0] ch = d[7:0];
    if (cl >= NCL || co >= NCO) return;
`ifdef STDOUT_UART_TAG_EN
    if (ch == 8'h0A) begin
      if (!m_ls) begin exp_q.push_back(8'h0A); m_ls = 1'b1; end
      return;
    end
    if (!m_ls && d[15:8] == m_last) begin exp_q.push_back(ch); return; end
    if (!m_ls) exp_q.push_back(8'h0A);
    exp_q.push_back("[");  exp_q.push_back(hexc(cl)); exp_q.push_back(",");
    exp_q.push_back(hexc(co)); exp_q.push_back("]"); exp_q.push_back(" ");
    exp_q.push_back(ch);
    m_ls   = 1'b0;
    m_last = d[15:8];
`else
    exp_q.push_back(ch);
`endif
  endtask

  // Drives one entry and returns just after its handshake edge
  task automatic send_entry(input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 4000) begin in_valid_i = 1'b0; @(negedge clk); n++; end
    nchecks++;
    if (!in_ready_o) begin
      nfail++;
      $display("FAIL handshake_timeout: in_ready_o=%b after %0d cycles, required 1", in_ready_o, n);
      in_valid_i = 1'b0;
    end else begin
      in_valid_i = 1'b1;
      in_data_i  = d;
      model_entry(d);
      @(posedge clk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    in_valid_i = 1'b0;
    while (!in_ready_o && n < 5000) begin @(negedge clk); n++; end
    nchecks++;
    if (!in_ready_o) begin
      nfail++;
      $display("FAIL idle_timeout: in_ready_o=%b, required 1", in_ready_o);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0;
    repeat (3) @(negedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    nchecks++; if (tx_o !== 1'b1) begin nfail++; $display("FAIL reset_tx: got %b required 1", tx_o); end
    nchecks++; if (in_ready_o !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %b required 1", in_ready_o); end
    nchecks++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b required 0", busy_o); end
  endtask

  task automatic test_drop();
    logic [15:0] drops[$];
`ifdef STDOUT_UART_TAG_EN
    drops.push_back(16'h000A);
`endif
    drops.push_back(16'h5041);
    drops.push_back(16'h0C41);
    foreach (drops[i]) begin
      exp_q.delete();
      send_entry(drops[i]);
      @(negedge clk);
      in_valid_i = 1'b0;
      nchecks++;
      if (busy_o !== 1'b1 || in_ready_o !== 1'b0 || tx_o !== 1'b1) begin
        nfail++;
        $display("FAIL drop_c1[%0d]: busy=%b ready=%b tx=%b required 1 0 1", i, busy_o, in_ready_o, tx_o);
      end
      @(negedge clk);
      nchecks++;
      if (busy_o !== 1'b0 || in_ready_o !== 1'b1 || tx_o !== 1'b1) begin
        nfail++;
        $display("FAIL drop_c2[%0d]: busy=%b ready=%b tx=%b required 0 1 1", i, busy_o, in_ready_o, tx_o);
      end
      nchecks++;
      if (exp_q.size() != 0) begin nfail++; $display("FAIL drop_model[%0d]: %0d bytes, required 0", i, exp_q.size()); end
    end
  endtask

  task automatic test_frame_timing();
    int nfr, bad = 0;
    logic [10*CD-1:0] got, want;
    logic [7:0] b;
    exp_q.delete();
    send_entry(16'h0041);
    nfr = exp_q.size();
    for (int f = 0; f < nfr; f++) begin
      b = exp_q[f];
      for (int c = 0; c < 10 * CD; c++) begin
        @(negedge clk);
        if (f == 0 && c == 0) in_valid_i = 1'b0;
        got[c]  = tx_o;
        want[c] = (c / CD == 0) ? 1'b0 : (c / CD == 9) ? 1'b1 : b[c / CD - 1];
        if (in_ready_o !== 1'b0 || busy_o !== 1'b1) bad++;
      end
      nchecks++;
      if (got !== want) begin nfail++; $display("FAIL frame_bits[%0d]: got %h required %h", f, got, want); end
    end
    nchecks++;
    if (bad != 0) begin nfail++; $display("FAIL frame_busy_ready: %0d bad cycles, required 0", bad); end
    @(negedge clk);
    nchecks++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      nfail++;
      $display("FAIL frame_end cycle %0d: ready=%b busy=%b required 1 0", nfr * 10 * CD + 1, in_ready_o, busy_o);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] ents[$] = '{16'h1268, 16'h1269, 16'h120A, 16'h0361, 16'h0B62,
                             16'h5041, 16'h0C63, 16'h3B0A, 16'h3B0A, 16'h3B7A};
    exp_q.delete(); rx_q.delete(); frame_err = 0;
    foreach (ents[i]) send_entry(ents[i]);
    wait_idle();
    nchecks++;
    if (rx_q.size() != exp_q.size()) begin nfail++; $display("FAIL directed_count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (rx_q[i] !== exp_q[i]) begin nfail++; $display("FAIL directed_byte[%0d]: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    nchecks++;
    if (frame_err != 0) begin nfail++; $display("FAIL directed_stop: %0d bad stop bits, required 0", frame_err); end
  endtask

  task automatic test_reset_midframe();
    int zb = 3;
    logic [7:0] b;
    exp_q.delete(); rx_q.delete();
    send_entry(16'h0041);
    b = exp_q[0];
    if (b[3] != 1'b0) begin zb = 0; while (b[zb] != 1'b0) zb++; end
    for (int c = 0; c < (zb + 1) * CD + CD / 2; c++) begin
      @(negedge clk);
      in_valid_i = 1'b0;
    end
    nchecks++;
    if (tx_o !== 1'b0) begin nfail++; $display("FAIL midframe_pre: tx=%b required 0", tx_o); end
    #1 rst_i = 1'b1;
    #1;
    nchecks++;
    if (tx_o !== 1'b1 || in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      nfail++;
      $display("FAIL midframe_async: tx=%b ready=%b busy=%b required 1 1 0", tx_o, in_ready_o, busy_o);
    end
    m_ls = 1'b1; m_last = '0; exp_q.delete();
    @(negedge clk);
    #1 rst_i = 1'b0;
    rx_q.delete();
    send_entry(16'h215A);
    wait_idle();
    nchecks++;
    if (rx_q.size() != exp_q.size()) begin nfail++; $display("FAIL midframe_count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (rx_q[i] !== exp_q[i]) begin nfail++; $display("FAIL midframe_byte[%0d]: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] src = 8'h00;
    logic [7:0] ch;
    exp_q.delete(); rx_q.delete(); frame_err = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) src = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
      ch = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'(32 + $urandom_range(0, 94));
      send_entry({src, ch});
    end
    wait_idle();
    nchecks++;
    if (rx_q.size() != exp_q.size()) begin nfail++; $display("FAIL random_count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (rx_q[i] !== exp_q[i]) begin nfail++; $display("FAIL random_byte[%0d]: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    nchecks++;
    if (frame_err != 0) begin nfail++; $display("FAIL random_stop: %0d bad stop bits, required 0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_drop();
    test_frame_timing();
    test_directed();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/stdout_uart_tx.md
# stdout_uart_tx

Downstream drain for the stdout character stream in FPGA builds. Accepts one tagged character per handshake from the stdout FIFO output: 8-bit char plus cluster/core index. Serializes it onto a UART TX pin as 8N1. When tagging is compiled in, each output line starts with a `[c,k] ` source prefix, and interleaved sources are split onto separate lines, so host-side logs match the simulation display format.

## Interface
- `N_CLUSTERS`, default 4: number of valid cluster indices; entries with a higher index are dropped.
- `N_CORES`, default 8: number of valid core indices; entries with a higher index are dropped.
- `CLK_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `clk_i` input 1: clock, single domain.
- `rst_i` input 1: asynchronous, active-high reset.
- `in_valid_i` input 1: entry valid.
- `in_ready_o` output 1: block can accept an entry.
- `in_data_i` input 16: [7:0] char, [11:8] core index, [15:12] cluster index.
- `tx_o` output 1: UART serial out; idles high.
- `busy_o` output 1: high while an entry is being processed or a frame is on the line.

## Operation
- Byte sequencer FSM states:
  - IDLE: in_ready_o=1.
  - NL: emit 0x0A.
  - PFX0..PFX5: emit `[`, hex(cl), `,`, hex(core), `]`, space.
  - CHAR: emit the captured char.
  - WAIT: wait for the serializer to finish the current frame.
- Acceptance: on in_valid_i && in_ready_o, latch in_data_i; in_ready_o drops the next cycle. in_ready_o returns to 1 in the cycle after the last frame's stop bit ends.
- Out-of-range entry (cl ≥ N_CLUSTERS or core ≥ N_CORES): still accepted, nothing emitted; FSM returns to IDLE the next cycle.
- Hex digit encoding: d<10 → 0x30+d; d≥10 → 0x61+d−10 (lowercase).
- Tagging state (macro on):
  - `line_start` flag, set at reset.
  - `last_src` register, 8 bits.
- Decision on an accepted in-range entry (macro on), evaluated in order:
  - char==0x0A and line_start: drop; this is the empty-line rule.
  - char==0x0A: emit 0x0A, then set line_start.
  - line_start: emit PFX0..PFX5, then char, then clear line_start; last_src ← src.
  - src≠last_src: emit NL, PFX0..PFX5, char; last_src ← src.
  - otherwise: emit char only.
- Serializer frame: start bit 0, data bits LSB first, stop bit 1. Each bit holds tx_o for exactly CLK_DIV cycles, so one byte is 10·CLK_DIV cycles. The bit counter is 4 bits and the divider counter is 16 bits, both wrapping to 0 at the end of each bit or frame.
- Back-to-back bytes within one entry: the next start bit begins in the cycle immediately after the previous stop bit ends, with no idle gap.

## Timing
- Reset values: tx_o=1, in_ready_o=1, busy_o=0, FSM=IDLE, line_start=1, last_src=0. Counters are 0.
- Latency: the start bit appears on tx_o one cycle after the handshake cycle.
- busy_o=1 from the cycle after the handshake until in_ready_o reasserts.
- Reset asserted mid-frame: tx_o goes high immediately (asynchronously). The partial frame and the captured entry are discarded, and line_start is set.
- in_valid_i while in_ready_o=0: held upstream; the stream protocol requires data to stay stable until accepted.
- A drop (out-of-range or empty line) consumes exactly one busy cycle.

## Configuration
- `STDOUT_UART_TAG_EN`:
  - Defined: prefixing, source-switch newline insertion and empty-line dropping as above.
  - Undefined:
    - Every in-range char, including 0x0A, is emitted raw as a single frame.
    - line_start and last_src are not implemented.
    - Out-of-range entries are still dropped.

## Test plan
- CLK_DIV=4, macro off, send cl=0 core=0 char 0x41 → tx_o low for cycles 1–4 after the handshake, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 4 cycles. in_ready_o returns at cycle 41.
- Macro on, cl=1 core=2 sending "hi\n" → UART bytes `[1,2] hi\n`, i.e. 0x5B 0x31 0x2C 0x32 0x5D 0x20 0x68 0x69 0x0A.
- Macro on, cl=0 core=3 sends 'a', then cl=0 core=11 sends 'b' (N_CORES=16) → `[0,3] a\n[0,b] b`.
- Macro on, 0x0A sent right after reset → accepted, tx_o stays high, busy_o high for 1 cycle only.
- cl=5 (N_CLUSTERS=4) char 0x41 → accepted, no frame emitted.
- rst_i pulsed mid data bit 3 → tx_o=1 in the same cycle. The next accepted in-range char (macro on) is prefixed.
